// File: rtl/average.sv
// ---------------------------------------------------------------------------
// average
//   Block averager for the acquisition path. It sums 2**LOG2_N consecutive
//   unsigned samples, one per clock. At the end of each window it outputs
//   the mean together with a one-cycle start strobe. The downstream
//   sample-and-hold latches val_avg when start is high.
//
//   Optional build macro: AVERAGE_ROUND_EN
//     defined   : round half up, result clamped to 2**DATA_W-1
//     undefined : truncating shift (default)
//   Timing and the start strobe are the same in both builds.
//
// Parameters
//   DATA_W   sample and average width (unsigned)
//   LOG2_N   log2 of the window length, legal range 1..8
//
// Ports
//   clk      in   1       system clock, rising edge
//   rstn     in   1       synchronous active-low reset
//   val      in   DATA_W  input sample, accepted every clock while rstn=1
//   val_avg  out  DATA_W  registered mean of the last completed window
//   start    out  1       one-cycle strobe; val_avg was updated this cycle
// ---------------------------------------------------------------------------
module average #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LOG2_N = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] val,
  output logic [DATA_W-1:0] val_avg,
  output logic              start
);

  // The accumulator is LOG2_N bits wider than a sample, so a full window
  // of maximum-value samples cannot overflow it.
  localparam int unsigned ACC_W = DATA_W + LOG2_N;

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  sum;
  logic [LOG2_N-1:0] cnt;
  logic [DATA_W-1:0] avg_next;

`ifdef AVERAGE_ROUND_EN
  localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (LOG2_N - 1);

  logic [ACC_W:0]  sum_rnd;
  logic [DATA_W:0] quot;

  always_comb begin
    sum      = acc + ACC_W'(val);
    sum_rnd  = {1'b0, sum} + HALF;
    quot     = (DATA_W+1)'(sum_rnd >> LOG2_N);
    avg_next = quot[DATA_W] ? '1 : quot[DATA_W-1:0];
  end
`else
  always_comb begin
    sum      = acc + ACC_W'(val);
    avg_next = DATA_W'(sum >> LOG2_N);
  end
`endif

  // The sample taken on the wrap edge belongs to the closing window.
  // It goes into the result directly and is not added to acc.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc     <= '0;
      cnt     <= '0;
      val_avg <= '0;
      start   <= 1'b0;
    end else begin
      start <= 1'b0;
      if (cnt == '1) begin
        val_avg <= avg_next;
        start   <= 1'b1;
        acc     <= '0;
        cnt     <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_average.sv
// ---------------------------------------------------------------------------
// tb_average
//   Self-checking bench for average (DATA_W=16, LOG2_N=4). A reference
//   model compares every cycle. It keeps the samples of the current window
//   in a queue and computes the mean with plain integer arithmetic.
//   Directed steps cover the documented cases. Randomized windows follow.
//   A behavioural sample-and-hold driven by start is also checked.
// ---------------------------------------------------------------------------
module tb_average;

  localparam int unsigned DW = 16;
  localparam int unsigned LN = 4;
  localparam int unsigned N  = 1 << LN;
`ifdef AVERAGE_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] val = '0;
  logic [DW-1:0] val_avg;
  logic          start;

  average #(.DATA_W(DW), .LOG2_N(LN)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .val     (val),
    .val_avg (val_avg),
    .start   (start)
  );

  always #5 clk = ~clk;

  // Downstream sample-and-hold: latches val_avg on the start strobe.
  logic [DW-1:0] sh_out;
  always @(posedge clk) begin
    if (!rstn)      sh_out <= '0;
    else if (start) sh_out <= val_avg;
  end

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model state
  int unsigned   win[$];
  int unsigned   exp_avg   = 0;
  bit            exp_start = 1'b0;
  bit            prev_start = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned mean_of(input int unsigned s);
    int unsigned m;
    if (RND) m = (s + N / 2) / N;
    else     m = s / N;
    if (m > 65535) m = 65535;
    return m;
  endfunction

  // Drive one clock of stimulus. Advance the model. Compare all outputs.
  task automatic step(input logic r, input logic [DW-1:0] v);
    int unsigned s;
    rstn = r;
    val  = v;
    @(posedge clk);
    #1;
    if (!r) begin
      win.delete();
      exp_avg   = 0;
      exp_start = 1'b0;
    end else begin
      win.push_back(v);
      exp_start = 1'b0;
      if (win.size() == N) begin
        s = 0;
        foreach (win[i]) s += win[i];
        exp_avg   = mean_of(s);
        exp_start = 1'b1;
        win.delete();
      end
    end
    check("val_avg", val_avg, exp_avg);
    check("start", start, exp_start);
    check("start_not_double", {31'd0, prev_start & start}, 0);
    prev_start = start;
  endtask

  initial begin
    int k;

    // 1: reset for two cycles with val at full scale, then full-scale windows
    step(1'b0, 16'hFFFF);
    check("rst_avg", val_avg, 0);
    check("rst_start", start, 0);
    step(1'b0, 16'hFFFF);
    check("rst_avg2", val_avg, 0);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 16'hFFFF);
      check("sh_before_strobe", sh_out, 0);
    end
    check("max_avg", val_avg, 65535);
    check("max_start", start, 1);
    for (int i = 0; i < 16; i++) step(1'b1, 16'hFFFF);
    check("max_start_2nd", start, 1);
    check("sh_after_strobe", sh_out, 65535);

    // 2: ramp 0..15
    for (int i = 0; i < 16; i++) step(1'b1, DW'(i));
    check("ramp", val_avg, RND ? 8 : 7);

    // 3: alternating 0 / 65535
    for (int i = 0; i < 16; i++) step(1'b1, (i % 2) ? 16'hFFFF : 16'h0000);
    check("alt", val_avg, RND ? 32768 : 32767);

    // 4: one sample of 15, the rest zero
    for (int i = 0; i < 16; i++) step(1'b1, (i == 5) ? 16'd15 : 16'd0);
    check("single15", val_avg, RND ? 1 : 0);

    // 5: reset mid-window discards the partial sum
    for (int i = 0; i < 10; i++) step(1'b1, 16'd1000);
    step(1'b0, 16'd1000);
    check("midrst_start", start, 0);
    for (int i = 0; i < 15; i++) step(1'b1, 16'd2000);
    check("midrst_nostrobe", start, 0);
    step(1'b1, 16'd2000);
    check("midrst_avg", val_avg, 2000);
    check("midrst_strobe", start, 1);

    // 6: randomized windows with occasional random partial-window resets
    for (int w = 0; w < 40; w++) begin
      if ($urandom_range(0, 4) == 0) begin
        k = int'($urandom_range(1, 15));
        for (int i = 0; i < k; i++) step(1'b1, DW'($urandom));
        step(1'b0, DW'($urandom));
      end
      for (int i = 0; i < 16; i++) step(1'b1, DW'($urandom));
      check("rand_strobe", start, 1);
    end

    // 7: hold between strobes
    step(1'b1, 16'd4);
    check("hold_after_strobe", val_avg, exp_avg);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
